reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 28 ++
 rtl/sb_match.sv | 58 +++++
 rtl/reg_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
// Holds the stage-entry layout {a3, we, tnew}, the default Tnew/Tuse width,
// the forwarding-source encodings and a saturating tnew decrement helper.
package reg_scoreboard_pkg;

  localparam int unsigned TNEW_W = 2;

  typedef logic [TNEW_W-1:0] tnew_t;

  typedef struct packed {
    logic [4:0] a3;
    logic       we;
    tnew_t      tnew;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // One cycle closer to the result; never wraps below zero.
  function automatic tnew_t tnew_dec(input tnew_t t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Per-operand hazard resolution for one D-stage source register.
// Finds the youngest in-flight stage (E, then M, then W) that writes the
// operand, reports it as the forwarding source, whether its value exists
// yet, and whether D must stall because the value is needed too early.
// Ports:
//   valid    D-stage instruction present (gates stall only)
//   src_use  operand is actually read
//   src      operand register number
//   tuse     cycles until D needs the value
//   e, m, w  current stage entries
//   fwd      forwarding source (GRF/E/M/W)
//   rdy      selected source value is valid now
//   stall    operand hazard requires a stall
module sb_match
  import reg_scoreboard_pkg::*;
(
  input  logic       valid,
  input  logic       src_use,
  input  logic [4:0] src,
  input  tnew_t      tuse,
  input  stage_t     e,
  input  stage_t     m,
  input  stage_t     w,
  output logic [1:0] fwd,
  output logic       rdy,
  output logic       stall
);

  logic  live;
  logic  hit_e, hit_m, hit_w;
  tnew_t tnew_sel;

  // Register 0 is hardwired and never produced by the pipeline.
  assign live  = src_use && (src != 5'd0);
  assign hit_e = live && e.we && (e.a3 == src);
  assign hit_m = live && m.we && (m.a3 == src);
  assign hit_w = live && w.we && (w.a3 == src);

  // Youngest match wins; older writers of the same register are shadowed.
  always_comb begin
    fwd      = FWD_GRF;
    tnew_sel = '0;
    if (hit_e) begin
      fwd      = FWD_E;
      tnew_sel = e.tnew;
    end else if (hit_m) begin
      fwd      = FWD_M;
      tnew_sel = m.tnew;
    end else if (hit_w) begin
      fwd      = FWD_W;
      tnew_sel = w.tnew;
    end
  end

  assign rdy   = (tnew_sel == '0);
  assign stall = valid && (fwd != FWD_GRF) && (tnew_sel > tuse);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a 5-stage pipeline.
// Tracks destination writes in flight through E, M and W, and resolves
// D-stage operand hazards into a stall request and forwarding selects.
// Stage storage uses the package Tnew width; TNEW_W defaults to it.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   d_valid                    D-stage instruction present
//   d_rs/d_rt, *_use, d_tuse_* source operands and when they are needed
//   d_a3, d_we, d_tnew         destination write of the D instruction
//   stall                      freeze PC/D, inject bubble into E
//   fwd_rs/fwd_rt, *_rdy       forwarding source and its readiness
//   w_a3, w_we                 W-stage register-file write port
module reg_scoreboard #(
  parameter int unsigned TNEW_W = reg_scoreboard_pkg::TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_a3,
  input  logic              d_we,
  input  logic [TNEW_W-1:0] d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic              fwd_rs_rdy,
  output logic              fwd_rt_rdy,
  output logic [4:0]        w_a3,
  output logic              w_we
);

  import reg_scoreboard_pkg::*;

  stage_t e_q, m_q, w_q;
  stage_t e_d, m_d, w_d;
  logic   stall_rs, stall_rt;

  sb_match u_match_rs (
    .valid   (d_valid),
    .src_use (d_rs_use),
    .src     (d_rs),
    .tuse    (tnew_t'(d_tuse_rs)),
    .e       (e_q),
    .m       (m_q),
    .w       (w_q),
    .fwd     (fwd_rs),
    .rdy     (fwd_rs_rdy),
    .stall   (stall_rs)
  );

  sb_match u_match_rt (
    .valid   (d_valid),
    .src_use (d_rt_use),
    .src     (d_rt),
    .tuse    (tnew_t'(d_tuse_rt)),
    .e       (e_q),
    .m       (m_q),
    .w       (w_q),
    .fwd     (fwd_rt),
    .rdy     (fwd_rt_rdy),
    .stall   (stall_rt)
  );

  assign stall = stall_rs | stall_rt;

  always_comb begin
    e_d = BUBBLE;
    if (d_valid && !stall) begin
      e_d.a3   = d_a3;
      // A write to register 0 is dropped at entry so it can never match.
      e_d.we   = d_we && (d_a3 != 5'd0);
      e_d.tnew = tnew_t'(d_tnew);
    end
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign w_a3 = w_q.a3;
  assign w_we = w_q.we;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: the stimulus process pushes expected
// per-cycle outputs and expected register-file writes into queues; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic       d_rs_use = 1'b0, d_rt_use = 1'b0, d_we = 1'b0;
  logic [1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic       stall, fwd_rs_rdy, fwd_rt_rdy, w_we;
  logic [1:0] fwd_rs, fwd_rt;
  logic [4:0] w_a3;

  reg_scoreboard #(.TNEW_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_use   (d_rs_use),
    .d_rt_use   (d_rt_use),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_we       (d_we),
    .d_tnew     (d_tnew),
    .stall      (stall),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .fwd_rs_rdy (fwd_rs_rdy),
    .fwd_rt_rdy (fwd_rt_rdy),
    .w_a3       (w_a3),
    .w_we       (w_we)
  );

  always #5 clk = ~clk;

  // Packed view: {stall, fwd_rs, rs_rdy, fwd_rt, rt_rdy, w_we, w_a3}
  typedef struct {
    string       name;
    int          cyc;
    logic [12:0] vec;
  } exp_t;

  typedef struct {
    logic [4:0] a3;
    int         cyc;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic rs_use,
                       input logic [1:0] tuse_rs, input logic [4:0] rt, input logic rt_use,
                       input logic [1:0] tuse_rt, input logic [4:0] a3, input logic we,
                       input logic [1:0] tnew);
    d_valid = v; d_rs = rs; d_rs_use = rs_use; d_tuse_rs = tuse_rs;
    d_rt = rt; d_rt_use = rt_use; d_tuse_rt = tuse_rt;
    d_a3 = a3; d_we = we; d_tnew = tnew;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_out(input string name, input logic st, input logic [1:0] frs,
                            input logic rrs, input logic [1:0] frt, input logic rrt,
                            input logic wwe, input logic [4:0] wa3);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.vec  = {st, frs, rrs, frt, rrt, wwe, wa3};
    exp_q.push_back(e);
  endtask

  task automatic expect_quiet(input string name);
    expect_out(name, 0, 0, 1, 0, 1, 0, 0);
  endtask

  task automatic expect_wb(input logic [4:0] a3, input int at);
    wb_t w;
    w.a3  = a3;
    w.cyc = at;
    wb_q.push_back(w);
  endtask

  // Monitor
  initial begin
    exp_t        e;
    wb_t         w;
    logic [12:0] obs;
    forever begin
      @(negedge clk);
      obs = {stall, fwd_rs, fwd_rs_rdy, fwd_rt, fwd_rt_rdy, w_we, w_a3};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL %s: check at cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e.vec) begin
          n_fail++;
          $display("FAIL %s: got {stall,frs,rrs,frt,rrt,wwe,wa3}=%b_%b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%b_%0d",
                   e.name, obs[12], obs[11:10], obs[9], obs[8:7], obs[6], obs[5], obs[4:0],
                   e.vec[12], e.vec[11:10], e.vec[9], e.vec[8:7], e.vec[6], e.vec[5], e.vec[4:0]);
        end
      end
      if (w_we) begin
        n_cmp++;
        if (wb_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got w_we=1 w_a3=%0d at cycle %0d, want no write", w_a3, cyc);
        end else begin
          w = wb_q.pop_front();
          if (w_a3 !== w.a3 || cyc != w.cyc) begin
            n_fail++;
            $display("FAIL wb_write: got a3=%0d at cycle %0d, want a3=%0d at cycle %0d",
                     w_a3, cyc, w.a3, w.cyc);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (exp_q.size() != 0 || wb_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: got %0d checks and %0d writes pending, want 0 and 0",
                   exp_q.size(), wb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus by 100000, want completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int c;
    idle();
    step();
    step();
    expect_quiet("reset_state");
    reset = 1'b0;

    // Producer tnew=2, consumer needs it immediately: two stall cycles, after
    // which the producer has advanced to W and is ready.
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 8, 1, 2); c = cyc;
    expect_quiet("t1_issue"); expect_wb(8, c + 3);
    step(); set_d(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("t1_stall_e", 1, 1, 0, 0, 1, 0, 0);
    step(); expect_out("t1_stall_m", 1, 2, 0, 0, 1, 0, 0);
    step(); expect_out("t1_fwd_w", 0, 3, 1, 0, 1, 1, 8);
    step(); idle(); expect_quiet("t1_idle");

    // tnew=0 producer forwards from E; rs and rt naming the same register agree.
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 8, 1, 0); c = cyc;
    expect_quiet("t2_issue"); expect_wb(8, c + 3);
    step(); set_d(1, 8, 1, 1, 8, 1, 1, 0, 0, 0);
    expect_out("t2_fwd_e", 0, 1, 1, 1, 1, 0, 0);
    step(); idle(); expect_quiet("t2_gap");
    step(); expect_out("t2_wb", 0, 0, 1, 0, 1, 1, 8);

    // Writes to register 0 are dropped entirely.
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 0, 1, 2); expect_quiet("t3_issue");
    step(); set_d(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); expect_quiet("t3_r0_read");
    step(); idle(); expect_quiet("t3_gap");
    step(); expect_quiet("t3_no_wb");

    // Younger tnew=0 writer shadows an older tnew=1 writer of the same register.
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 5, 1, 2); c = cyc;
    expect_quiet("t4_issue_old"); expect_wb(5, c + 3);
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 5, 1, 0);
    expect_quiet("t4_issue_new"); expect_wb(5, c + 4);
    step(); set_d(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("t4_shadow", 0, 1, 1, 0, 1, 0, 0);
    step(); idle(); expect_out("t4_wb_old", 0, 0, 1, 0, 1, 1, 5);
    step(); expect_out("t4_wb_new", 0, 0, 1, 0, 1, 1, 5);

    // rt with tuse=1: stalls while tnew=2, not when tnew equals tuse.
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 12, 1, 2); c = cyc;
    expect_quiet("t5_issue"); expect_wb(12, c + 3);
    step(); set_d(1, 0, 0, 0, 12, 1, 1, 0, 0, 0);
    expect_out("t5_stall", 1, 0, 1, 1, 0, 0, 0);
    step(); expect_out("t5_eq_tuse", 0, 0, 1, 2, 0, 0, 0);
    step(); idle(); expect_out("t5_wb", 0, 0, 1, 0, 1, 1, 12);

    // Invalid D never stalls; then reset during a stall flushes everything.
    step(); set_d(1, 0, 0, 0, 0, 0, 0, 7, 1, 3); expect_quiet("t6_issue");
    step(); set_d(0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("t6_invalid", 0, 1, 0, 0, 1, 0, 0);
    step(); set_d(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); reset = 1'b1;
    expect_out("t6_stall", 1, 2, 0, 0, 1, 0, 0);
    step(); reset = 1'b0; idle(); expect_quiet("t6_after_reset");
    step(); expect_quiet("t6_flush1");
    step(); expect_quiet("t6_flush2");

    step();
    done = 1'b1;
  end

endmodule
